// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-N stream demultiplexer.
package demux_pkg;
    localparam int MODE_SEL = 0;   // route each beat by its explicit select
    localparam int MODE_RR  = 1;   // route by the internal round-robin pointer
    localparam int CNT_W    = 16;  // width of the accepted-beat counter
endpackage

// File: rtl/stream_demux_1ton_if.sv
// Handshake bundle between one producer and N consumers of the demux.
interface stream_demux_1ton_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic            s_valid;
    logic            s_ready;
    logic [W-1:0]    s_data;
    logic [SW-1:0]   s_sel;
    logic [N-1:0]    m_valid;
    logic [N-1:0]    m_ready;
    logic [N*W-1:0]  m_data;

    // Environment side: drives the input stream and the consumer readies.
    modport master (
        output s_valid, s_data, s_sel, m_ready,
        input  s_ready, m_valid, m_data
    );

    // Demux side: accepts the input stream and presents the channels.
    modport slave (
        input  s_valid, s_data, s_sel, m_ready,
        output s_ready, m_valid, m_data
    );
endinterface

// File: rtl/demux_chan_reg.sv
// One-entry holding register for a single output channel.
// A load wins over a drain in the same cycle so a channel can take a new
// beat every cycle while its consumer keeps up.
module demux_chan_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data
);
    logic         r_valid;
    logic [W-1:0] r_data;

    // Hold the beat until the consumer takes it; reload on the same edge if offered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N stream demultiplexer with per-channel holding registers.
// The target channel comes either from the input select or from a strict
// round-robin pointer; a busy target back-pressures the input, other
// channels keep flowing. Out-of-range selects are swallowed and flagged.
module stream_demux_1ton
    import demux_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    parameter  int MODE = MODE_SEL,
    localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    stream_demux_1ton_if.slave bus,
    output logic [SW-1:0]     rr_ptr,
    output logic              err_drop,
    output logic [CNT_W-1:0]  beat_cnt
);
    localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

    logic [SW-1:0]    r_rr_ptr;
    logic             r_err_drop;
    logic [CNT_W-1:0] r_beat_cnt;

    logic [SW-1:0]    w_tgt;
    logic             w_tgt_ok;
    logic             w_tgt_busy;
    logic             w_accept;
    logic [N-1:0]     w_load;
    logic [N-1:0]     w_valid;
    logic [N*W-1:0]   w_data;

    assign w_tgt    = (MODE == MODE_RR) ? r_rr_ptr : bus.s_sel;
    assign w_tgt_ok = (int'(w_tgt) < N);

    // Target is busy when it holds a beat its consumer is not taking this cycle.
    always_comb begin
        w_tgt_busy = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (int'(w_tgt) == k) begin
                w_tgt_busy = w_valid[k] & ~bus.m_ready[k];
            end
        end
    end

    assign bus.s_ready = ~w_tgt_busy;
    assign w_accept    = bus.s_valid & ~w_tgt_busy;

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_chan
            assign w_load[k] = w_accept && (w_tgt == SW'(k));

            demux_chan_reg #(.W(W)) u_chan (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_load[k]),
                .i_data  (bus.s_data),
                .i_ready (bus.m_ready[k]),
                .o_valid (w_valid[k]),
                .o_data  (w_data[k*W +: W])
            );
        end
    endgenerate

    assign bus.m_valid = w_valid;
    assign bus.m_data  = w_data;

    // Round-robin pointer moves only when a beat is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if ((MODE == MODE_RR) && w_accept) begin
            r_rr_ptr <= (r_rr_ptr == LAST_CH) ? '0 : r_rr_ptr + 1'b1;
        end
    end

    // Flag discarded beats for one cycle and count beats that reached a channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_drop <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_err_drop <= w_accept & ~w_tgt_ok;
            if (w_accept && w_tgt_ok) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    assign rr_ptr   = r_rr_ptr;
    assign err_drop = r_err_drop;
    assign beat_cnt = r_beat_cnt;
endmodule

// File: tb/tb_stream_demux_1ton.sv
// Bench for stream_demux_1ton: select mode (N=4), round-robin mode (N=4)
// and select mode with a non-power-of-two channel count (N=3).
module tb_stream_demux_1ton;
    import demux_pkg::*;

    typedef struct {
        int         ch;
        logic [7:0] d;
    } beat_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    beat_t sb_q[$];

    stream_demux_1ton_if #(.N(4), .W(8)) ifA ();
    stream_demux_1ton_if #(.N(4), .W(8)) ifB ();
    stream_demux_1ton_if #(.N(3), .W(8)) ifC ();

    logic [1:0]  rrA, rrB, rrC;
    logic        errA, errB, errC;
    logic [15:0] cntA, cntB, cntC;

    stream_demux_1ton #(.N(4), .W(8), .MODE(MODE_SEL)) dutA (
        .clk(clk), .rst_n(rst_n), .bus(ifA), .rr_ptr(rrA), .err_drop(errA), .beat_cnt(cntA));
    stream_demux_1ton #(.N(4), .W(8), .MODE(MODE_RR)) dutB (
        .clk(clk), .rst_n(rst_n), .bus(ifB), .rr_ptr(rrB), .err_drop(errB), .beat_cnt(cntB));
    stream_demux_1ton #(.N(3), .W(8), .MODE(MODE_SEL)) dutC (
        .clk(clk), .rst_n(rst_n), .bus(ifC), .rr_ptr(rrC), .err_drop(errC), .beat_cnt(cntC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        ifA.s_valid = 0; ifA.s_data = 0; ifA.s_sel = 0; ifA.m_ready = '0;
        ifB.s_valid = 0; ifB.s_data = 0; ifB.s_sel = 0; ifB.m_ready = '0;
        ifC.s_valid = 0; ifC.s_data = 0; ifC.s_sel = 0; ifC.m_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ifA.m_valid !== 4'b0) begin errors++; $display("FAIL rst_validA: got %b want 0", ifA.m_valid); end
        checks++; if (ifA.m_data !== 32'h0) begin errors++; $display("FAIL rst_dataA: got %h want 0", ifA.m_data); end
        checks++; if (cntA !== 16'd0) begin errors++; $display("FAIL rst_cntA: got %0d want 0", cntA); end
        checks++; if (errA !== 1'b0) begin errors++; $display("FAIL rst_errA: got %b want 0", errA); end
        checks++; if (ifB.m_valid !== 4'b0) begin errors++; $display("FAIL rst_validB: got %b want 0", ifB.m_valid); end
        checks++; if (rrB !== 2'd0) begin errors++; $display("FAIL rst_rrB: got %0d want 0", rrB); end
        checks++; if (cntB !== 16'd0) begin errors++; $display("FAIL rst_cntB: got %0d want 0", cntB); end
        checks++; if (ifC.m_valid !== 3'b0) begin errors++; $display("FAIL rst_validC: got %b want 0", ifC.m_valid); end
        checks++; if (errC !== 1'b0) begin errors++; $display("FAIL rst_errC: got %b want 0", errC); end
        rst_n = 1'b1;
    endtask

    task automatic test_sel_basic();
        beat_t e;
        sb_q.delete();
        ifA.m_ready = 4'hF;
        for (int i = 0; i <= 4; i++) begin
            @(posedge clk); #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (ifA.m_valid !== 4'(1 << e.ch)) begin
                    errors++; $display("FAIL sel_valid: got %b want %b", ifA.m_valid, 4'(1 << e.ch));
                end
                checks++;
                if (ifA.m_data[e.ch*8 +: 8] !== e.d) begin
                    errors++; $display("FAIL sel_data ch%0d: got %h want %h", e.ch, ifA.m_data[e.ch*8 +: 8], e.d);
                end
            end
            if (i < 4) begin
                ifA.s_valid = 1'b1;
                ifA.s_data  = 8'(8'hA0 + i);
                ifA.s_sel   = 2'(3 - i);
                #1;
                checks++;
                if (ifA.s_ready !== 1'b1) begin errors++; $display("FAIL sel_ready: got %b want 1", ifA.s_ready); end
                sb_q.push_back('{3 - i, 8'(8'hA0 + i)});
            end else begin
                ifA.s_valid = 1'b0;
            end
        end
        checks++; if (cntA !== 16'd4) begin errors++; $display("FAIL sel_cnt: got %0d want 4", cntA); end
    endtask

    task automatic test_backpressure();
        ifA.m_ready = 4'b1011;
        @(posedge clk); #1;
        ifA.s_valid = 1'b1; ifA.s_data = 8'h11; ifA.s_sel = 2'd2;
        #1;
        checks++; if (ifA.s_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b want 1", ifA.s_ready); end
        @(posedge clk); #1;
        checks++; if (ifA.m_valid[2] !== 1'b1 || ifA.m_data[23:16] !== 8'h11) begin
            errors++; $display("FAIL bp_load11: got v=%b d=%h want v=1 d=11", ifA.m_valid[2], ifA.m_data[23:16]); end
        ifA.s_data = 8'h22; ifA.s_sel = 2'd2;
        #1;
        checks++; if (ifA.s_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: got %b want 0", ifA.s_ready); end
        @(posedge clk); #1;
        checks++; if (ifA.m_valid[2] !== 1'b1 || ifA.m_data[23:16] !== 8'h11) begin
            errors++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=11", ifA.m_valid[2], ifA.m_data[23:16]); end
        checks++; if (cntA !== 16'd5) begin errors++; $display("FAIL bp_cnt1: got %0d want 5", cntA); end
        ifA.s_data = 8'h33; ifA.s_sel = 2'd1;
        #1;
        checks++; if (ifA.s_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_ch1: got %b want 1", ifA.s_ready); end
        @(posedge clk); #1;
        checks++; if (ifA.m_valid[1] !== 1'b1 || ifA.m_data[15:8] !== 8'h33) begin
            errors++; $display("FAIL bp_ch1: got v=%b d=%h want v=1 d=33", ifA.m_valid[1], ifA.m_data[15:8]); end
        checks++; if (ifA.m_data[23:16] !== 8'h11) begin errors++; $display("FAIL bp_ch2_kept: got %h want 11", ifA.m_data[23:16]); end
        ifA.s_data = 8'h22; ifA.s_sel = 2'd2; ifA.m_ready = 4'b1111;
        #1;
        checks++; if (ifA.s_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_comb: got %b want 1", ifA.s_ready); end
        @(posedge clk); #1;
        checks++; if (ifA.m_valid[2] !== 1'b1 || ifA.m_data[23:16] !== 8'h22) begin
            errors++; $display("FAIL bp_drain_load: got v=%b d=%h want v=1 d=22", ifA.m_valid[2], ifA.m_data[23:16]); end
        checks++; if (cntA !== 16'd7) begin errors++; $display("FAIL bp_cnt2: got %0d want 7", cntA); end
        ifA.s_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (ifA.m_valid !== 4'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", ifA.m_valid); end
    endtask

    task automatic test_reset_mid();
        ifA.m_ready = 4'b0000;
        @(posedge clk); #1;
        ifA.s_valid = 1'b1; ifA.s_data = 8'h01; ifA.s_sel = 2'd1;
        @(posedge clk); #1;
        ifA.s_data = 8'h02; ifA.s_sel = 2'd2;
        @(posedge clk); #1;
        ifA.s_valid = 1'b0;
        checks++; if (ifA.m_valid !== 4'b0110) begin errors++; $display("FAIL mid_pre: got %b want 0110", ifA.m_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ifA.m_valid !== 4'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", ifA.m_valid); end
        checks++; if (cntA !== 16'd0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", cntA); end
        checks++; if (ifA.m_data !== 32'h0) begin errors++; $display("FAIL mid_data: got %h want 0", ifA.m_data); end
        #2 rst_n = 1'b1;
        ifA.m_ready = 4'hF;
    endtask

    task automatic test_round_robin();
        beat_t e;
        sb_q.delete();
        ifB.m_ready = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (ifB.m_valid[e.ch] !== 1'b1 || ifB.m_data[e.ch*8 +: 8] !== e.d) begin
                    errors++; $display("FAIL rr_out ch%0d: got v=%b d=%h want v=1 d=%h",
                                       e.ch, ifB.m_valid[e.ch], ifB.m_data[e.ch*8 +: 8], e.d);
                end
            end
            checks++;
            if (rrB !== 2'(i % 4)) begin errors++; $display("FAIL rr_ptr%0d: got %0d want %0d", i, rrB, i % 4); end
            ifB.s_valid = 1'b1;
            ifB.s_data  = 8'(8'h60 + i);
            ifB.s_sel   = 2'($urandom_range(0, 3));
            #1;
            checks++;
            if (ifB.s_ready !== 1'b1) begin errors++; $display("FAIL rr_ready%0d: got %b want 1", i, ifB.s_ready); end
            sb_q.push_back('{i % 4, 8'(8'h60 + i)});
        end
        @(posedge clk); #1;
        e = sb_q.pop_front();
        checks++;
        if (ifB.m_valid[e.ch] !== 1'b1 || ifB.m_data[e.ch*8 +: 8] !== e.d) begin
            errors++; $display("FAIL rr_last ch%0d: got d=%h want %h", e.ch, ifB.m_data[e.ch*8 +: 8], e.d);
        end
        checks++; if (rrB !== 2'd2) begin errors++; $display("FAIL rr_ptr_end: got %0d want 2", rrB); end
        ifB.s_data = 8'h66;
        #1;
        checks++; if (ifB.s_ready !== 1'b0) begin errors++; $display("FAIL rr_stall: got %b want 0", ifB.s_ready); end
        @(posedge clk); #1;
        checks++; if (rrB !== 2'd2) begin errors++; $display("FAIL rr_ptr_stall: got %0d want 2", rrB); end
        checks++; if (ifB.m_valid[2] !== 1'b1 || ifB.m_data[23:16] !== 8'h62) begin
            errors++; $display("FAIL rr_ch2_hold: got v=%b d=%h want v=1 d=62", ifB.m_valid[2], ifB.m_data[23:16]); end
        checks++; if (cntB !== 16'd6) begin errors++; $display("FAIL rr_cnt: got %0d want 6", cntB); end
        ifB.m_ready = 4'hF;
        #1;
        checks++; if (ifB.s_ready !== 1'b1) begin errors++; $display("FAIL rr_release: got %b want 1", ifB.s_ready); end
        @(posedge clk); #1;
        ifB.s_valid = 1'b0;
        checks++; if (ifB.m_valid[2] !== 1'b1 || ifB.m_data[23:16] !== 8'h66) begin
            errors++; $display("FAIL rr_ch2_new: got v=%b d=%h want v=1 d=66", ifB.m_valid[2], ifB.m_data[23:16]); end
        checks++; if (rrB !== 2'd3) begin errors++; $display("FAIL rr_ptr_adv: got %0d want 3", rrB); end
    endtask

    task automatic test_bad_select();
        ifC.m_ready = 3'b000;
        @(posedge clk); #1;
        ifC.s_valid = 1'b1; ifC.s_data = 8'h44; ifC.s_sel = 2'd1;
        @(posedge clk); #1;
        checks++; if (ifC.m_valid !== 3'b010) begin errors++; $display("FAIL bad_pre: got %b want 010", ifC.m_valid); end
        checks++; if (cntC !== 16'd1) begin errors++; $display("FAIL bad_cnt_pre: got %0d want 1", cntC); end
        ifC.s_data = 8'h5A; ifC.s_sel = 2'd3;
        #1;
        checks++; if (ifC.s_ready !== 1'b1) begin errors++; $display("FAIL bad_ready: got %b want 1", ifC.s_ready); end
        @(posedge clk); #1;
        ifC.s_valid = 1'b0;
        checks++; if (errC !== 1'b1) begin errors++; $display("FAIL bad_err: got %b want 1", errC); end
        checks++; if (ifC.m_valid !== 3'b010) begin errors++; $display("FAIL bad_valid: got %b want 010", ifC.m_valid); end
        checks++; if (ifC.m_data !== 24'h004400) begin errors++; $display("FAIL bad_data: got %h want 004400", ifC.m_data); end
        checks++; if (cntC !== 16'd1) begin errors++; $display("FAIL bad_cnt: got %0d want 1", cntC); end
        checks++; if (rrC !== 2'd0) begin errors++; $display("FAIL bad_rr: got %0d want 0", rrC); end
        @(posedge clk); #1;
        checks++; if (errC !== 1'b0) begin errors++; $display("FAIL bad_err_pulse: got %b want 0", errC); end
    endtask

    task automatic test_cnt_wrap();
        ifC.m_ready = 3'b111;
        ifC.s_valid = 1'b1; ifC.s_data = 8'h00; ifC.s_sel = 2'd0;
        repeat (65534) @(posedge clk);
        #1;
        checks++; if (cntC !== 16'd65535) begin errors++; $display("FAIL wrap_max: got %0d want 65535", cntC); end
        @(posedge clk); #1;
        ifC.s_valid = 1'b0;
        checks++; if (cntC !== 16'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", cntC); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sel_basic();
        test_backpressure();
        test_reset_mid();
        test_round_robin();
        test_bad_select();
        test_cnt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
